// File: rtl/i2c_pkg.sv
// Shared I2C definitions: one-hot primary FSM states, quarter-slot encoding and ACK/NACK levels.
package i2c_pkg;

    localparam int unsigned NumStates = 13;

    typedef enum logic [NumStates-1:0] {
        StIdle  = 13'h0001,
        StStart = 13'h0002,
        StAddr  = 13'h0004,
        StAckA  = 13'h0008,
        StWrHi  = 13'h0010,
        StAckHi = 13'h0020,
        StWrLo  = 13'h0040,
        StAckLo = 13'h0080,
        StRdHi  = 13'h0100,
        StMack  = 13'h0200,
        StRdLo  = 13'h0400,
        StMnack = 13'h0800,
        StStop  = 13'h1000
    } state_e;

    typedef enum logic [1:0] {
        QtrQ0 = 2'd0,
        QtrQ1 = 2'd1,
        QtrQ2 = 2'd2,
        QtrQ3 = 2'd3
    } quarter_e;

    localparam logic [2:0] BitMsb = 3'd7;
    localparam logic       Ack    = 1'b0;
    localparam logic       Nack   = 1'b1;

    // SCL is low for the first half of every data, ack and stop slot.
    function automatic logic scl_level(quarter_e qtr);
        return (qtr == QtrQ2) || (qtr == QtrQ3);
    endfunction

endpackage

// File: rtl/i2c_primary_if.sv
// Host request/status and two-wire bus signals of the I2C primary.
interface i2c_primary_if;

    logic        start_stb;
    logic        rnw;
    logic [6:0]  i2c_addr;
    logic [15:0] wr_data;
    logic        sda_in;
    logic        scl;
    logic        sda_out;
    logic        sda_oe;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        nack_err;

    modport master (
        input  start_stb, rnw, i2c_addr, wr_data, sda_in,
        output scl, sda_out, sda_oe, rd_data, busy, done, nack_err
    );

    modport slave (
        output start_stb, rnw, i2c_addr, wr_data, sda_in,
        input  scl, sda_out, sda_oe, rd_data, busy, done, nack_err
    );

endinterface

// File: rtl/i2c_slot_timer.sv
// Quarter-bit timebase: splits each bit slot into four quarters of Quarter clock cycles.
module i2c_slot_timer
    import i2c_pkg::*;
#(
    parameter int unsigned Quarter = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     run_i,
    output quarter_e qtr_nxt_o,
    output logic     slot_end_o,
    output logic     q0_start_o,
    output logic     sample_pulse_o
);

    localparam int unsigned     CntW   = (Quarter > 1) ? $clog2(Quarter) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Quarter - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    quarter_e        qtr_q, qtr_d;
    logic [1:0]      qtr_inc;
    logic            cnt_first, cnt_last;

    assign cnt_first = (cnt_q == '0);
    assign cnt_last  = (cnt_q == CntMax);
    assign qtr_inc   = 2'(qtr_q) + 2'd1;

    // Idle holds the timer at Q0 so a new slot always starts on a clean boundary.
    always_comb begin
        cnt_d = '0;
        qtr_d = QtrQ0;
        if (run_i) begin
            cnt_d = cnt_last ? '0 : cnt_q + CntW'(1);
            qtr_d = cnt_last ? quarter_e'(qtr_inc) : qtr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            qtr_q <= QtrQ0;
        end else begin
            cnt_q <= cnt_d;
            qtr_q <= qtr_d;
        end
    end

    assign qtr_nxt_o      = qtr_d;
    assign slot_end_o     = run_i && (qtr_q == QtrQ3) && cnt_last;
    assign q0_start_o     = run_i && (qtr_q == QtrQ0) && cnt_first;
    assign sample_pulse_o = run_i && (qtr_q == QtrQ3) && cnt_first;

endmodule

// File: rtl/i2c_primary.sv
// I2C primary: one 16-bit read or write per request, with START/STOP generation and NACK reporting.
module i2c_primary
    import i2c_pkg::*;
#(
    parameter int unsigned Quarter = 2
) (
    input logic           clk_i,
    input logic           rst_i,
    i2c_primary_if.master bus_io
);

    state_e      state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic        rnw_q;
    logic [6:0]  addr_q;
    logic [15:0] wr_q, hold_q, hold_d, rd_data_q;
    logic        nack_q, done_q, busy_q, scl_q, sda_q, oe_q;
    logic        scl_d, sda_d, oe_d;
    logic [7:0]  tx_byte;
    logic        running, accept, in_byte, in_ack, nack_hit, nack_now, stop_end;
    logic        slot_end, q0_start, sample_pulse;
    quarter_e    qtr_nxt;

    assign running = (state_q != StIdle);

    i2c_slot_timer #(
        .Quarter(Quarter)
    ) u_timer (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .run_i          (running),
        .qtr_nxt_o      (qtr_nxt),
        .slot_end_o     (slot_end),
        .q0_start_o     (q0_start),
        .sample_pulse_o (sample_pulse)
    );

    assign accept   = (state_q == StIdle) && bus_io.start_stb;
    assign in_byte  = state_q inside {StAddr, StWrHi, StWrLo, StRdHi, StRdLo};
    assign in_ack   = state_q inside {StAckA, StAckHi, StAckLo};
    assign nack_hit = in_ack && sample_pulse && (bus_io.sda_in == Nack);
    assign nack_now = nack_q || nack_hit;
    assign stop_end = (state_q == StStop) && slot_end;

    always_comb begin
        state_d = state_q;
        if (slot_end) begin
            unique case (state_q)
                StStart: state_d = StAddr;
                StAddr:  if (bit_q == '0) state_d = StAckA;
                StAckA:  state_d = nack_now ? StStop : (rnw_q ? StRdHi : StWrHi);
                StWrHi:  if (bit_q == '0) state_d = StAckHi;
                StAckHi: state_d = nack_now ? StStop : StWrLo;
                StWrLo:  if (bit_q == '0) state_d = StAckLo;
                StAckLo: state_d = StStop;
                StRdHi:  if (bit_q == '0) state_d = StMack;
                StMack:  state_d = StRdLo;
                StRdLo:  if (bit_q == '0) state_d = StMnack;
                StMnack: state_d = StStop;
                default: state_d = StIdle;
            endcase
        end else if (accept) begin
            state_d = StStart;
        end
    end

    // The 3-bit index wraps from 0 back to MSB as each byte ends.
    assign bit_d = (in_byte && slot_end) ? bit_q - 3'd1 : bit_q;

    always_comb begin
        hold_d = hold_q;
        if (q0_start && (state_q == StRdHi) && (bit_q == BitMsb)) begin
            hold_d = '0;
        end else if (sample_pulse && (state_q inside {StRdHi, StRdLo})) begin
            hold_d = {hold_q[14:0], bus_io.sda_in};
        end
    end

    always_comb begin
        unique case (state_d)
            StAddr:  tx_byte = {addr_q, rnw_q};
            StWrHi:  tx_byte = wr_q[15:8];
            default: tx_byte = wr_q[7:0];
        endcase
    end

    // Bus outputs are decoded from the next state so the registers line up with the slot.
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        oe_d  = 1'b0;
        unique case (state_d)
            StIdle: begin
            end
            StStart: begin
                oe_d  = 1'b1;
                sda_d = (qtr_nxt == QtrQ0) || (qtr_nxt == QtrQ1);
            end
            StAddr, StWrHi, StWrLo: begin
                scl_d = scl_level(qtr_nxt);
                oe_d  = 1'b1;
                sda_d = tx_byte[bit_d];
            end
            StMack, StMnack: begin
                scl_d = scl_level(qtr_nxt);
                oe_d  = 1'b1;
                sda_d = (state_d == StMack) ? Ack : Nack;
            end
            StStop: begin
                scl_d = scl_level(qtr_nxt);
                oe_d  = 1'b1;
                sda_d = (qtr_nxt == QtrQ3);
            end
            default: begin
                scl_d = scl_level(qtr_nxt);
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            bit_q     <= BitMsb;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            wr_q      <= '0;
            hold_q    <= '0;
            rd_data_q <= '0;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            oe_q    <= oe_d;
            done_q  <= stop_end;
            busy_q  <= (state_d != StIdle);
            if (accept) begin
                rnw_q  <= bus_io.rnw;
                addr_q <= bus_io.i2c_addr;
                wr_q   <= bus_io.wr_data;
                nack_q <= 1'b0;
            end else if (nack_hit) begin
                nack_q <= 1'b1;
            end
            if (stop_end && rnw_q && !nack_q) begin
                rd_data_q <= hold_q;
            end
        end
    end

    assign bus_io.scl      = scl_q;
    assign bus_io.sda_out  = sda_q;
    assign bus_io.sda_oe   = oe_q;
    assign bus_io.rd_data  = rd_data_q;
    assign bus_io.busy     = busy_q;
    assign bus_io.done     = done_q;
    assign bus_io.nack_err = nack_q;

endmodule

// File: tb/tb_i2c_primary.sv
// Bench for i2c_primary: a bus-level secondary model checks each byte against a scoreboard,
// directed steps check timing, status flags and reset behaviour.
module tb_i2c_primary;
    import i2c_pkg::*;

    localparam int unsigned Q        = 2;
    localparam int          Full     = 1 + 116 * Q;
    localparam int          AddrNack = 1 + 44 * Q;
    localparam int          HiNack   = 1 + 80 * Q;
    localparam int          Limit    = 400;

    typedef struct packed {
        logic [7:0] data;
        logic       ack;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    i2c_primary_if dif ();

    i2c_primary #(
        .Quarter(Q)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic a);
        exp_t e;
        e.data = d;
        e.ack  = a;
        exp_q.push_back(e);
    endtask

    // Secondary model: wired-AND line, START/STOP detection, bit capture on SCL rise.
    logic [6:0]  m_addr = 7'h2A;
    int          m_nack_byte = 0;
    logic [15:0] m_rd = 16'h1234;
    logic        m_active, m_rw, m_hit, scl_p, line_p, line;
    logic [7:0]  m_sh;
    int          m_bitpos, m_byte;
    exp_t        m_e;

    assign line = (dif.sda_oe ? dif.sda_out : 1'b1) & dif.sda_in;

    always @(negedge clk) begin
        if (rst) begin
            m_active   = 1'b0;
            m_rw       = 1'b0;
            m_hit      = 1'b0;
            m_bitpos   = 0;
            m_byte     = 0;
            m_sh       = '0;
            dif.sda_in = 1'b1;
        end else if (scl_p && dif.scl && line_p && !line) begin
            m_active   = 1'b1;
            m_bitpos   = 0;
            m_byte     = 0;
            dif.sda_in = 1'b1;
        end else if (scl_p && dif.scl && !line_p && line) begin
            m_active   = 1'b0;
            dif.sda_in = 1'b1;
        end else if (m_active && !scl_p && dif.scl) begin
            if (m_bitpos < 8) m_sh = {m_sh[6:0], line};
            m_bitpos++;
            if (m_bitpos == 8 && m_byte == 0) begin
                m_rw  = m_sh[0];
                m_hit = (m_sh[7:1] == m_addr);
            end else if (m_bitpos == 9) begin
                chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    m_e = exp_q.pop_front();
                    chk("sb_byte", {23'd0, m_sh, line}, {23'd0, m_e});
                end
                m_byte++;
                m_bitpos = 0;
            end
        end else if (m_active && scl_p && !dif.scl) begin
            dif.sda_in = 1'b1;
            if (m_bitpos == 8 && m_byte == 0) begin
                dif.sda_in = m_hit ? Ack : Nack;
            end else if (m_bitpos == 8 && !m_rw && m_hit) begin
                dif.sda_in = (m_byte == m_nack_byte) ? Nack : Ack;
            end else if (m_rw && m_hit && m_bitpos < 8 && m_byte == 1) begin
                dif.sda_in = m_rd[15 - m_bitpos];
            end else if (m_rw && m_hit && m_bitpos < 8 && m_byte == 2) begin
                dif.sda_in = m_rd[7 - m_bitpos];
            end
        end
        scl_p  = dif.scl;
        line_p = line;
    end

    // Issues one request from the current cycle and runs until DONE or the cycle budget.
    task automatic run_txn(input logic r, input logic [6:0] a, input logic [15:0] d,
                           input int stray_at, output int cyc, output int oe_low,
                           output int scl_low, output logic nack1, output logic nackd,
                           output logic [15:0] rdd);
        dif.rnw       = r;
        dif.i2c_addr  = a;
        dif.wr_data   = d;
        dif.start_stb = 1'b1;
        cyc     = -1;
        oe_low  = 0;
        scl_low = dif.scl ? 0 : 1;
        nack1   = 1'bx;
        nackd   = 1'bx;
        rdd     = 'x;
        for (int n = 1; n <= Limit; n++) begin
            @(posedge clk);
            #1;
            dif.start_stb = (n == stray_at);
            if (n == stray_at) begin
                dif.rnw      = ~r;
                dif.i2c_addr = 7'h11;
                dif.wr_data  = 16'h0000;
            end
            if (n == 1) nack1 = dif.nack_err;
            if (n <= 8 && !dif.scl) scl_low++;
            if (dif.busy && !dif.sda_oe) oe_low++;
            if (dif.done) begin
                cyc   = n;
                nackd = dif.nack_err;
                rdd   = dif.rd_data;
                break;
            end
        end
        dif.start_stb = 1'b0;
    endtask

    int          cyc, oe_low, scl_low;
    logic        nack1, nackd;
    logic [15:0] rdd;

    initial begin
        dif.start_stb = 1'b0;
        dif.rnw       = 1'b0;
        dif.i2c_addr  = '0;
        dif.wr_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_scl", dif.scl, 1);
        chk("rst_sda_out", dif.sda_out, 1);
        chk("rst_sda_oe", dif.sda_oe, 0);
        chk("rst_rd_data", dif.rd_data, 0);
        chk("rst_busy", dif.busy, 0);
        chk("rst_done", dif.done, 0);
        chk("rst_nack", dif.nack_err, 0);

        // Write 0xBEEF to 0x2A with a stray request in the middle of the address byte.
        push(8'h54, Ack);
        push(8'hBE, Ack);
        push(8'hEF, Ack);
        run_txn(1'b0, 7'h2A, 16'hBEEF, 50, cyc, oe_low, scl_low, nack1, nackd, rdd);
        chk("wr_done_cycle", cyc, Full);
        chk("wr_oe_low_cycles", oe_low, 3 * 4 * Q);
        chk("wr_nack", nackd, 0);
        chk("wr_rd_data_hold", rdd, 16'h0000);
        chk("wr_sb_empty", exp_q.size(), 0);

        // Read 0x1234 from 0x2A; MACK after HI, MNACK after LO.
        @(posedge clk);
        #1;
        push(8'h55, Ack);
        push(8'h12, Ack);
        push(8'h34, Nack);
        run_txn(1'b1, 7'h2A, 16'h0000, 0, cyc, oe_low, scl_low, nack1, nackd, rdd);
        chk("rd_done_cycle", cyc, Full);
        chk("rd_data", rdd, 16'h1234);
        chk("rd_nack", nackd, 0);
        chk("rd_sb_empty", exp_q.size(), 0);

        // Secondary answers 0x11 only: address NACK, short transaction, RD_DATA kept.
        @(posedge clk);
        #1;
        m_addr = 7'h11;
        m_rd   = 16'hFFFF;
        push(8'h55, Nack);
        run_txn(1'b1, 7'h2A, 16'h0000, 0, cyc, oe_low, scl_low, nack1, nackd, rdd);
        chk("anack_done_cycle", cyc, AddrNack);
        chk("anack_nack", nackd, 1);
        chk("anack_rd_data", rdd, 16'h1234);
        chk("anack_sb_empty", exp_q.size(), 0);

        // NACK on the HI data byte of a write: LO byte skipped.
        @(posedge clk);
        #1;
        m_addr      = 7'h2A;
        m_nack_byte = 1;
        push(8'h54, Ack);
        push(8'hBE, Nack);
        run_txn(1'b0, 7'h2A, 16'hBEEF, 0, cyc, oe_low, scl_low, nack1, nackd, rdd);
        chk("hnack_done_cycle", cyc, HiNack);
        chk("hnack_nack", nackd, 1);
        chk("hnack_sb_empty", exp_q.size(), 0);

        // Back-to-back request on the DONE cycle; it also clears NACK_ERR.
        m_nack_byte = 0;
        push(8'h54, Ack);
        push(8'h0F, Ack);
        push(8'hA5, Ack);
        run_txn(1'b0, 7'h2A, 16'h0FA5, 0, cyc, oe_low, scl_low, nack1, nackd, rdd);
        chk("b2b_nack_cleared", nack1, 0);
        chk("b2b_scl_low_cycles", scl_low, 0);
        chk("b2b_done_cycle", cyc, Full);
        chk("b2b_nack", nackd, 0);
        chk("b2b_rd_data", rdd, 16'h1234);
        chk("b2b_sb_empty", exp_q.size(), 0);

        // Reset during bit 3 of the HI read byte.
        @(posedge clk);
        #1;
        m_rd = 16'h5A5A;
        push(8'h55, Ack);
        dif.rnw       = 1'b1;
        dif.i2c_addr  = 7'h2A;
        dif.start_stb = 1'b1;
        for (int n = 1; n <= 115; n++) begin
            @(posedge clk);
            #1;
            dif.start_stb = 1'b0;
        end
        chk("mid_busy", dif.busy, 1);
        chk("mid_sb_empty", exp_q.size(), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_scl", dif.scl, 1);
        chk("mid_rst_oe", dif.sda_oe, 0);
        chk("mid_rst_sda_out", dif.sda_out, 1);
        chk("mid_rst_busy", dif.busy, 0);
        chk("mid_rst_rd_data", dif.rd_data, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
